// File: rtl/hdmi_pkg.sv
// Shared constants for the DVI/HDMI period scheduler and the downstream
// encoder mux: guard-band codes, video preamble control bits and slot types.
package hdmi_pkg;

  localparam logic [9:0] GB_CH0 = 10'b1011001100;
  localparam logic [9:0] GB_CH1 = 10'b0100110011;
  localparam logic [9:0] GB_CH2 = 10'b1011001100;

  localparam logic [1:0] PRE_VIDEO_CD1 = 2'b01;
  localparam logic [1:0] PRE_VIDEO_CD2 = 2'b00;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;

  typedef enum logic [1:0] {
    SLOT_CONTROL,
    SLOT_PREAMBLE,
    SLOT_GUARD,
    SLOT_ACTIVE
  } slot_e;

endpackage

// File: rtl/hdmi_video_timing.sv
// Horizontal/vertical timing counters plus sync and region decode.
// Starts on the first blanking line so a frame opens with a full vertical blank.
module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  output logic o_hs,
  output logic o_vs,
  output logic o_h_act,
  output logic o_h_pre,
  output logic o_h_gb,
  output logic o_line_act,
  output logic o_next_act,
  output logic o_origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_PRE_BEG  = HW'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [HW-1:0] H_GB_BEG   = HW'(H_TOTAL - GUARD_LEN);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Back porch must hold the whole preamble plus guard band.
  if (H_BP < PREAMBLE_LEN + GUARD_LEN || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
    $error("hdmi_video_timing: invalid timing parameters");
  end

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (i_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q <= '0;
      vcnt_q <= V_ACT_END;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign o_hs       = (hcnt_q >= H_SYNC_BEG && hcnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
  assign o_vs       = (vcnt_q >= V_SYNC_BEG && vcnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
  assign o_h_act    = (hcnt_q < H_ACT_END);
  assign o_h_pre    = (hcnt_q >= H_PRE_BEG) && (hcnt_q < H_GB_BEG);
  assign o_h_gb     = (hcnt_q >= H_GB_BEG);
  assign o_line_act = (vcnt_q < V_ACT_END);
  assign o_next_act = (vcnt_q == V_LAST) || (vcnt_q < V_ACT_LAST);
  assign o_origin   = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-slot period scheduler for a video-only DVI/HDMI link: classifies each
// pixel slot, requests pixels and registers the fields for the TMDS encoders.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  output logic       o_req,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic       o_en,
  output logic       o_vde,
  output logic       o_gb,
  output logic [1:0] o_cd0,
  output logic [1:0] o_cd1,
  output logic [1:0] o_cd2,
  output logic [7:0] o_vd0,
  output logic [7:0] o_vd1,
  output logic [7:0] o_vd2,
  output logic       o_frame_start
);

  logic hs, vs, h_act, h_pre, h_gb, line_act, next_act, origin;
  slot_e slot;

  hdmi_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk       (clk),
    .rstn      (rstn),
    .i_en      (i_en),
    .o_hs      (hs),
    .o_vs      (vs),
    .o_h_act   (h_act),
    .o_h_pre   (h_pre),
    .o_h_gb    (h_gb),
    .o_line_act(line_act),
    .o_next_act(next_act),
    .o_origin  (origin)
  );

  always_comb begin
    slot = SLOT_CONTROL;
    if (line_act && h_act)       slot = SLOT_ACTIVE;
    else if (next_act && h_gb)   slot = SLOT_GUARD;
    else if (next_act && h_pre)  slot = SLOT_PREAMBLE;
  end

  assign o_req = i_en && (slot == SLOT_ACTIVE);

  logic       en_q, en_d, vde_q, vde_d, gb_q, gb_d, fs_q, fs_d;
  logic [1:0] cd0_q, cd0_d, cd1_q, cd1_d, cd2_q, cd2_d;
  logic [7:0] vd0_q, vd0_d, vd1_q, vd1_d, vd2_q, vd2_d;

  always_comb begin
    en_d  = i_en;
    vde_d = vde_q;
    gb_d  = gb_q;
    fs_d  = fs_q;
    cd0_d = cd0_q;
    cd1_d = cd1_q;
    cd2_d = cd2_q;
    vd0_d = vd0_q;
    vd1_d = vd1_q;
    vd2_d = vd2_q;
    if (i_en) begin
      vde_d = 1'b0;
      gb_d  = 1'b0;
      fs_d  = 1'b0;
      cd0_d = {vs, hs};
      cd1_d = 2'b00;
      cd2_d = 2'b00;
      vd0_d = '0;
      vd1_d = '0;
      vd2_d = '0;
      case (slot)
        SLOT_PREAMBLE: begin
          cd1_d = PRE_VIDEO_CD1;
          cd2_d = PRE_VIDEO_CD2;
        end
        SLOT_GUARD: begin
          vde_d = 1'b1;
          gb_d  = 1'b1;
        end
        SLOT_ACTIVE: begin
          vde_d = 1'b1;
          vd0_d = i_b;
          vd1_d = i_g;
          vd2_d = i_r;
          fs_d  = origin;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q  <= 1'b0;
      vde_q <= 1'b0;
      gb_q  <= 1'b0;
      fs_q  <= 1'b0;
      cd0_q <= '0;
      cd1_q <= '0;
      cd2_q <= '0;
      vd0_q <= '0;
      vd1_q <= '0;
      vd2_q <= '0;
    end else begin
      en_q  <= en_d;
      vde_q <= vde_d;
      gb_q  <= gb_d;
      fs_q  <= fs_d;
      cd0_q <= cd0_d;
      cd1_q <= cd1_d;
      cd2_q <= cd2_d;
      vd0_q <= vd0_d;
      vd1_q <= vd1_d;
      vd2_q <= vd2_d;
    end
  end

  assign o_en          = en_q;
  assign o_vde         = vde_q;
  assign o_gb          = gb_q;
  assign o_frame_start = fs_q;
  assign o_cd0         = cd0_q;
  assign o_cd1         = cd1_q;
  assign o_cd2         = cd2_q;
  assign o_vd0         = vd0_q;
  assign o_vd1         = vd1_q;
  assign o_vd2         = vd2_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler on a reduced 34x9 timing with VS_POL=1.
module tb_hdmi_period_scheduler;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 4, H_BP = 12;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int H_TOTAL = 34, V_TOTAL = 9;

  logic clk = 1'b0, rstn = 1'b0, i_en = 1'b0;
  logic [7:0] i_r = '0, i_g = '0, i_b = '0;
  logic o_req, o_en, o_vde, o_gb, o_frame_start;
  logic [1:0] o_cd0, o_cd1, o_cd2;
  logic [7:0] o_vd0, o_vd1, o_vd2;

  always #5 clk = ~clk;

  hdmi_period_scheduler #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .i_en(i_en), .o_req(o_req),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_en(o_en), .o_vde(o_vde), .o_gb(o_gb),
    .o_cd0(o_cd0), .o_cd1(o_cd1), .o_cd2(o_cd2),
    .o_vd0(o_vd0), .o_vd1(o_vd1), .o_vd2(o_vd2),
    .o_frame_start(o_frame_start)
  );

  typedef struct {
    logic       en, vde, gb, fs, chk_cd, chk_vd;
    logic [1:0] cd0, cd1, cd2;
    logic [7:0] vd0, vd1, vd2;
  } exp_t;

  typedef struct {
    int         v, h;
    logic       req, vde, gb, fs, chk_cd;
    logic [1:0] cd0, cd1;
  } vec_t;

  int   n_pass = 0, n_total = 0;
  int   mv = V_ACTIVE, mh = 0;
  int   cnt_req = 0, cnt_pre = 0, cnt_gb = 0, cnt_fs = 0;
  exp_t last_e;
  exp_t sb_q[$];
  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (model v=%0d h=%0d)", name, act, exp, mv, mh);
  endtask

  function automatic exp_t reset_exp();
    exp_t e = '{default: '0};
    e.chk_cd = 1'b1;
    e.chk_vd = 1'b1;
    return e;
  endfunction

  // Reference: classify by distance to the end of the line and the next line index.
  function automatic exp_t model_exp(input int v, input int h, input logic [7:0] r, g, b);
    exp_t e = '{default: '0};
    int   rem = H_TOTAL - 1 - h;
    bit   nxt = ((v + 1) % V_TOTAL) < V_ACTIVE;
    bit   hs  = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    bit   vs  = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    e.en  = 1'b1;
    e.cd0 = {vs, hs};
    if (v < V_ACTIVE && h < H_ACTIVE) begin
      e.vde = 1'b1; e.chk_vd = 1'b1;
      e.vd0 = b; e.vd1 = g; e.vd2 = r;
      e.fs  = (v == 0 && h == 0);
    end else if (nxt && rem < 2) begin
      e.vde = 1'b1; e.gb = 1'b1; e.chk_cd = 1'b1; e.chk_vd = 1'b1;
    end else if (nxt && rem < 10) begin
      e.cd1 = 2'b01; e.chk_cd = 1'b1;
    end else begin
      e.chk_cd = 1'b1;
    end
    return e;
  endfunction

  task automatic model_adv();
    if (mh == H_TOTAL - 1) begin
      mh = 0;
      mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic cmp(input exp_t e);
    check("o_en", o_en, e.en);
    check("o_vde", o_vde, e.vde);
    check("o_gb", o_gb, e.gb);
    check("o_frame_start", o_frame_start, e.fs);
    if (e.chk_cd) begin
      check("o_cd0", o_cd0, e.cd0);
      check("o_cd1", o_cd1, e.cd1);
      check("o_cd2", o_cd2, e.cd2);
    end
    if (e.chk_vd) begin
      check("o_vd0", o_vd0, e.vd0);
      check("o_vd1", o_vd1, e.vd1);
      check("o_vd2", o_vd2, e.vd2);
    end
  endtask

  // One slot: drive at negedge, push expectation, pop and compare after the edge.
  task automatic sb_cycle(input bit en);
    exp_t e;
    logic [7:0] r, g, b;
    if (en) begin
      r = 8'(mh * 3); g = 8'(mh * 5 + 1); b = ~8'(mh);
    end else begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    end
    i_en = en; i_r = r; i_g = g; i_b = b;
    #1;
    check("o_req", o_req, en && mv < V_ACTIVE && mh < H_ACTIVE);
    if (en) begin
      if (o_req) cnt_req++;
      e = model_exp(mv, mh, r, g, b);
      model_adv();
      last_e = e;
    end else begin
      e = last_e;
      e.en = 1'b0;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cmp(sb_q.pop_front());
    if (en) begin
      if (o_cd1 == 2'b01 && !o_vde) cnt_pre++;
      if (o_gb) cnt_gb++;
      if (o_frame_start) cnt_fs++;
    end
    @(negedge clk);
  endtask

  task automatic walk_to(input int v, input int h);
    int k = 0;
    while (!(mv == v && mh == h) && k < 700) begin
      sb_cycle(1'b1);
      k++;
    end
    if (k >= 700) begin
      n_total++;
      $display("FAIL walk_to: position v=%0d h=%0d not reached in %0d slots", v, h, k);
    end
  endtask

  task automatic first_req_check(input string tag);
    int k = 0;
    cnt_pre = 0; cnt_gb = 0;
    while (k < 400) begin
      i_en = 1'b1;
      #1;
      if (o_req) break;
      sb_cycle(1'b1);
      k++;
    end
    check({tag, "_first_req_slot"}, k, 5 * H_TOTAL);
    check({tag, "_preamble_before_first"}, cnt_pre, 8);
    check({tag, "_guard_before_first"}, cnt_gb, 2);
  endtask

  initial begin
    int n_en;
    last_e = reset_exp();
    // v, h, req, vde, gb, fs, chk_cd, cd0, cd1
    tbl[0]  = '{4, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[1]  = '{4, 19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
    tbl[2]  = '{4, 25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[3]  = '{5, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00};
    tbl[4]  = '{6, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
    tbl[5]  = '{7, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[6]  = '{8, 23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[7]  = '{8, 24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01};
    tbl[8]  = '{8, 31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01};
    tbl[9]  = '{8, 32, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[10] = '{8, 33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[11] = '{0, 0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[12] = '{0, 15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[13] = '{0, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[14] = '{0, 24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01};
    tbl[15] = '{0, 33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[16] = '{1, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[17] = '{3, 15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[18] = '{3, 24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00};
    tbl[19] = '{3, 33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00};

    repeat (3) @(negedge clk);
    check("reset_ctl", {o_en, o_vde, o_gb, o_frame_start, o_cd0, o_cd1, o_cd2}, '0);
    check("reset_vd", {o_vd0, o_vd1, o_vd2}, '0);
    check("reset_req", o_req, 1'b0);
    rstn = 1'b1;

    // Fixed-position vectors across the first blank and the first frame.
    for (int i = 0; i < 20; i++) begin
      walk_to(tbl[i].v, tbl[i].h);
      i_en = 1'b1;
      #1;
      check($sformatf("tbl%0d_req", i), o_req, tbl[i].req);
      sb_cycle(1'b1);
      check($sformatf("tbl%0d_vde", i), o_vde, tbl[i].vde);
      check($sformatf("tbl%0d_gb", i), o_gb, tbl[i].gb);
      check($sformatf("tbl%0d_fs", i), o_frame_start, tbl[i].fs);
      if (tbl[i].chk_cd) begin
        check($sformatf("tbl%0d_cd0", i), o_cd0, tbl[i].cd0);
        check($sformatf("tbl%0d_cd1", i), o_cd1, tbl[i].cd1);
      end
    end

    // Two whole frames with gapped enables: alternating, then random.
    walk_to(V_ACTIVE, 0);
    cnt_req = 0; cnt_pre = 0; cnt_gb = 0; cnt_fs = 0; n_en = 0;
    for (int i = 0; i < 3000 && n_en < 2 * H_TOTAL * V_TOTAL; i++) begin
      bit en;
      en = (n_en < H_TOTAL * V_TOTAL) ? (i % 2 == 0) : ($urandom_range(0, 2) != 0);
      sb_cycle(en);
      if (en) n_en++;
    end
    check("gapped_slots", n_en, 2 * H_TOTAL * V_TOTAL);
    check("gapped_req_count", cnt_req, 2 * 4 * 16);
    check("gapped_frame_starts", cnt_fs, 2);
    check("gapped_preamble_slots", cnt_pre, 2 * 4 * 8);
    check("gapped_guard_slots", cnt_gb, 2 * 4 * 2);

    // Asynchronous reset in the middle of an active line.
    walk_to(1, 5);
    #2 rstn = 1'b0;
    #1;
    check("midline_rst_ctl", {o_en, o_vde, o_gb, o_frame_start, o_cd0, o_cd1, o_cd2}, '0);
    check("midline_rst_vd", {o_vd0, o_vd1, o_vd2}, '0);
    check("midline_rst_req", o_req, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    mv = V_ACTIVE; mh = 0;
    last_e = reset_exp();
    first_req_check("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
